// File: rtl/coin_event_builder_if.sv
// FIFO write-port bundle between the coin event builder (master) and the event FIFO (slave).
`timescale 1ns/1ps
interface coin_event_builder_if;
  logic        FIFO_FULL;
  logic        WR_EN;
  logic [15:0] WR_DATA;

  modport master (input FIFO_FULL, output WR_EN, output WR_DATA);
  modport slave  (output FIFO_FULL, input WR_EN, input WR_DATA);
endinterface

// File: rtl/coin_event_builder.sv
// Coincidence-triggered event builder: synchronises coin/tube hits, ORs a pre-trigger history plus a hit window
// into one event and writes it as a 16-bit word frame. Optional EVENT_NUMBER_HEADER_EN prepends an event number.
`timescale 1ns/1ps
module coin_event_builder #(
  parameter int PRE_DEPTH = 4,
  parameter int WINDOW    = 10
) (
  input  logic                        clk100,
  input  logic                        reset,
  input  logic                        SCIN_COIN,
  input  logic [7:0]                  TUBE3A,
  input  logic [7:0]                  TUBE3B,
  input  logic [7:0]                  TUBE4A,
  input  logic [7:0]                  TUBE4B,
  coin_event_builder_if.master        fifo,
  output logic                        BUSY,
  output logic                        OVERFLOW
);

`ifdef EVENT_NUMBER_HEADER_EN
  localparam int FRAME_WORDS = 4;
`else
  localparam int FRAME_WORDS = 3;
`endif
  localparam logic [1:0] LAST_IDX = 2'(FRAME_WORDS - 1);
  localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WINDOW,
    ST_EMIT
  } state_t;

  // Coin and all tube bits share one synchroniser structure so their latencies are identical.
  logic [32:0] raw_vec;
  logic [32:0] sync_vec;
  logic        coin_sync;
  logic [31:0] tube_sync;

  assign raw_vec   = {SCIN_COIN, TUBE3A, TUBE3B, TUBE4A, TUBE4B};
  assign coin_sync = sync_vec[32];
  assign tube_sync = sync_vec[31:0];

  generate
    for (genvar gi = 0; gi < 33; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= raw_vec[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_vec[gi] = s2_reg;
    end
  endgenerate

  // Pre-trigger history: stage 0 holds the previous cycle's vector, stage PRE_DEPTH-1 the oldest.
  logic [PRE_DEPTH-1:0][31:0] hist_q;
  logic [31:0]                hist_or;

  generate
    for (genvar gi = 0; gi < PRE_DEPTH; gi++) begin : g_hist
      logic [31:0] stage_reg;
      logic [31:0] stage_in;
      if (gi == 0) begin : g_first
        assign stage_in = tube_sync;
      end else begin : g_chain
        assign stage_in = hist_q[gi-1];
      end
      always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= stage_in;
        end
      end
      assign hist_q[gi] = stage_reg;
    end
  endgenerate

  always_comb begin
    hist_or = '0;
    for (int i = 0; i < PRE_DEPTH; i++) begin
      hist_or = hist_or | hist_q[i];
    end
  end

  logic [15:0] ts_reg;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + 16'd1;
    end
  end

  state_t      state_reg,    state_next;
  logic [7:0]  win_cnt_reg,  win_cnt_next;
  logic [1:0]  word_idx_reg, word_idx_next;
  logic [31:0] acc_reg,      acc_next;
  logic [15:0] ts_cap_reg,   ts_cap_next;
  logic        armed_reg,    armed_next;
  logic        overflow_reg, overflow_next;
  logic [15:0] frame_word;
  logic        wr_en;
  logic        busy;
`ifdef EVENT_NUMBER_HEADER_EN
  logic [15:0] evt_cnt_reg, evt_cnt_next;
`endif

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      win_cnt_reg  <= '0;
      word_idx_reg <= '0;
      acc_reg      <= '0;
      ts_cap_reg   <= '0;
      armed_reg    <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef EVENT_NUMBER_HEADER_EN
      evt_cnt_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      win_cnt_reg  <= win_cnt_next;
      word_idx_reg <= word_idx_next;
      acc_reg      <= acc_next;
      ts_cap_reg   <= ts_cap_next;
      armed_reg    <= armed_next;
      overflow_reg <= overflow_next;
`ifdef EVENT_NUMBER_HEADER_EN
      evt_cnt_reg  <= evt_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    win_cnt_next  = win_cnt_reg;
    word_idx_next = word_idx_reg;
    acc_next      = acc_reg;
    ts_cap_next   = ts_cap_reg;
    armed_next    = armed_reg;
    overflow_next = overflow_reg;
    wr_en         = 1'b0;
    busy          = 1'b0;
`ifdef EVENT_NUMBER_HEADER_EN
    evt_cnt_next  = evt_cnt_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        // Arming only happens on a low level seen here, so a held or re-raised coin cannot retrigger.
        if (!coin_sync) begin
          armed_next = 1'b1;
        end
        if (coin_sync && armed_reg) begin
          armed_next   = 1'b0;
          acc_next     = hist_or | tube_sync;
          ts_cap_next  = ts_reg;
          win_cnt_next = '0;
          state_next   = ST_WINDOW;
        end
      end

      ST_WINDOW: begin
        busy         = 1'b1;
        acc_next     = acc_reg | tube_sync;
        win_cnt_next = win_cnt_reg + 8'd1;
        if (win_cnt_reg == WIN_LAST) begin
          word_idx_next = '0;
          state_next    = ST_EMIT;
        end
      end

      ST_EMIT: begin
        busy = 1'b1;
        if (fifo.FIFO_FULL) begin
          // Full on the first word drops the whole event; later it only stalls.
          if (word_idx_reg == 2'd0) begin
            overflow_next = 1'b1;
            state_next    = ST_IDLE;
          end
        end else begin
          wr_en = 1'b1;
          if (word_idx_reg == LAST_IDX) begin
            state_next = ST_IDLE;
`ifdef EVENT_NUMBER_HEADER_EN
            evt_cnt_next = evt_cnt_reg + 16'd1;
`endif
          end else begin
            word_idx_next = word_idx_reg + 2'd1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    frame_word = '0;
`ifdef EVENT_NUMBER_HEADER_EN
    case (word_idx_reg)
      2'd0:    frame_word = evt_cnt_reg;
      2'd1:    frame_word = ts_cap_reg;
      2'd2:    frame_word = acc_reg[31:16];
      default: frame_word = acc_reg[15:0];
    endcase
`else
    case (word_idx_reg)
      2'd0:    frame_word = ts_cap_reg;
      2'd1:    frame_word = acc_reg[31:16];
      2'd2:    frame_word = acc_reg[15:0];
      default: frame_word = '0;
    endcase
`endif
  end

  assign fifo.WR_EN   = wr_en;
  assign fifo.WR_DATA = (state_reg == ST_EMIT) ? frame_word : 16'h0000;
  assign BUSY         = busy;
  assign OVERFLOW     = overflow_reg;

endmodule

// File: tb/tb_coin_event_builder.sv
// Scoreboard bench for coin_event_builder: directed stimulus pushes expected words with their cycle numbers,
// a negedge monitor pops and compares every FIFO write.
`timescale 1ns/1ps
module tb_coin_event_builder;
  localparam int WINDOW    = 10;
  localparam int PRE_DEPTH = 4;
`ifdef EVENT_NUMBER_HEADER_EN
  localparam int NWORDS = 4;
`else
  localparam int NWORDS = 3;
`endif

  logic       clk100 = 1'b0;
  logic       reset  = 1'b1;
  logic       SCIN_COIN = 1'b0;
  logic [7:0] TUBE3A = '0;
  logic [7:0] TUBE3B = '0;
  logic [7:0] TUBE4A = '0;
  logic [7:0] TUBE4B = '0;
  logic       BUSY;
  logic       OVERFLOW;

  coin_event_builder_if fifo_if ();

  coin_event_builder #(
    .PRE_DEPTH(PRE_DEPTH),
    .WINDOW   (WINDOW)
  ) dut (
    .clk100   (clk100),
    .reset    (reset),
    .SCIN_COIN(SCIN_COIN),
    .TUBE3A   (TUBE3A),
    .TUBE3B   (TUBE3B),
    .TUBE4A   (TUBE4A),
    .TUBE4B   (TUBE4B),
    .fifo     (fifo_if),
    .BUSY     (BUSY),
    .OVERFLOW (OVERFLOW)
  );

  always #5 clk100 = ~clk100;

  // Cycle index since reset release; equals the expected timestamp counter value in that cycle.
  int cyc;
  always @(posedge clk100 or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   evt_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk100) begin
    if (!reset) begin
      if (BUSY) busy_cnt++;
      if (fifo_if.WR_EN) begin
        $display("wr cyc=%0d data=0x%04h", cyc, fifo_if.WR_DATA);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: got data 0x%04h at cycle %0d, expected no write", fifo_if.WR_DATA, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_data", 32'(fifo_if.WR_DATA), 32'(e.data));
          check("wr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  task automatic coin_rise(output int t);
    SCIN_COIN = 1'b1;
    t = cyc + 2;
  endtask

  task automatic push_frame(input int t, input logic [15:0] w1, input logic [15:0] w2,
                            input int stall, input int nw);
    logic [15:0] words[4];
    int k;
    k = 0;
`ifdef EVENT_NUMBER_HEADER_EN
    words[0] = evt_model[15:0];
    k = 1;
`endif
    words[k]   = t[15:0];
    words[k+1] = w1;
    words[k+2] = w2;
    for (int i = 0; i < nw; i++) begin
      exp_t e;
      e.data = words[i];
      e.cyc  = t + WINDOW + 1 + i + ((i > 0) ? stall : 0);
      exp_q.push_back(e);
    end
    if (nw == NWORDS) evt_model++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick(3);
    while ((BUSY || exp_q.size() != 0) && n < 300) begin
      tick(1);
      n++;
    end
    check("idle_wait_bound", (n < 300) ? 32'd1 : 32'd0, 32'd1);
    tick(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_wr_en", 32'(fifo_if.WR_EN), 32'd0);
    check("rst_wr_data", 32'(fifo_if.WR_DATA), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_overflow", 32'(OVERFLOW), 32'd0);
    evt_model = 0;
    @(negedge clk100);
    reset = 1'b0;
    tick(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 2 ms");
    $fatal(1);
  end

  initial begin
    int t;
    int t2;
    fifo_if.FIFO_FULL = 1'b0;

    repeat (3) @(posedge clk100);
    #1;
    check("init_wr_en", 32'(fifo_if.WR_EN), 32'd0);
    check("init_wr_data", 32'(fifo_if.WR_DATA), 32'd0);
    check("init_busy", 32'(BUSY), 32'd0);
    check("init_overflow", 32'(OVERFLOW), 32'd0);
    @(negedge clk100);
    reset = 1'b0;
    tick(1);

    // Idle after reset: no writes, not busy, no overflow.
    busy_cnt = 0;
    tick(200);
    check("idle_busy_cycles", 32'(busy_cnt), 32'd0);
    check("idle_overflow", 32'(OVERFLOW), 32'd0);

    // Basic event: TUBE3B[2] present at trigger, BUSY for WINDOW+NWORDS cycles.
    TUBE3B = 8'h04;
    tick(2);
    busy_cnt = 0;
    coin_rise(t);
    push_frame(t, 16'h0004, 16'h0000, 0, NWORDS);
    tick(10);
    SCIN_COIN = 1'b0;
    TUBE3B = 8'h00;
    wait_idle();
    check("busy_cycles", 32'(busy_cnt), 32'(WINDOW + NWORDS));

    // Pre-trigger history: pulse ending 2 cycles before the coin edge is caught.
    TUBE4B = 8'h01;
    tick(2);
    TUBE4B = 8'h00;
    tick(2);
    coin_rise(t);
    push_frame(t, 16'h0000, 16'h0001, 0, NWORDS);
    tick(3);
    SCIN_COIN = 1'b0;
    wait_idle();

    // Same pulse 6 cycles earlier falls outside the history.
    TUBE4B = 8'h01;
    tick(2);
    TUBE4B = 8'h00;
    tick(8);
    coin_rise(t);
    push_frame(t, 16'h0000, 16'h0000, 0, NWORDS);
    tick(3);
    SCIN_COIN = 1'b0;
    wait_idle();

    // Window end: hit at T+WINDOW counts.
    coin_rise(t);
    push_frame(t, 16'h8000, 16'h0000, 0, NWORDS);
    tick(WINDOW);
    TUBE3A = 8'h80;
    tick(1);
    TUBE3A = 8'h00;
    tick(2);
    SCIN_COIN = 1'b0;
    wait_idle();

    // Hit at T+WINDOW+1 is excluded; coin held high long after the frame must not retrigger.
    coin_rise(t);
    push_frame(t, 16'h0000, 16'h0000, 0, NWORDS);
    tick(WINDOW + 1);
    TUBE3A = 8'h80;
    tick(1);
    TUBE3A = 8'h00;
    tick(25);
    SCIN_COIN = 1'b0;
    wait_idle();

    // Second coin edge inside the window yields one frame only; next event's ts reflects trigger spacing.
    coin_rise(t);
    push_frame(t, 16'h0000, 16'h0000, 0, NWORDS);
    tick(2);
    SCIN_COIN = 1'b0;
    tick(3);
    SCIN_COIN = 1'b1;
    tick(2);
    SCIN_COIN = 1'b0;
    wait_idle();
    TUBE4A = 8'h3C;
    coin_rise(t2);
    push_frame(t2, 16'h0000, 16'h3C00, 0, NWORDS);
    tick(2);
    SCIN_COIN = 1'b0;
    TUBE4A = 8'h00;
    wait_idle();

    // FIFO full at EMIT entry: event dropped, sticky overflow.
    fifo_if.FIFO_FULL = 1'b1;
    coin_rise(t);
    tick(2);
    SCIN_COIN = 1'b0;
    wait_idle();
    check("drop_overflow", 32'(OVERFLOW), 32'd1);
    tick(20);
    check("overflow_sticky", 32'(OVERFLOW), 32'd1);
    fifo_if.FIFO_FULL = 1'b0;
    do_reset();

    // Full for 3 cycles after the first word: later words delayed, values intact.
    TUBE3A = 8'h5A;
    TUBE4A = 8'hC3;
    tick(1);
    coin_rise(t);
    push_frame(t, 16'h5A00, 16'hC300, 3, NWORDS);
    tick(2);
    SCIN_COIN = 1'b0;
    TUBE3A = 8'h00;
    TUBE4A = 8'h00;
    tick(WINDOW + 2);
    fifo_if.FIFO_FULL = 1'b1;
    tick(3);
    fifo_if.FIFO_FULL = 1'b0;
    wait_idle();
    check("stall_overflow", 32'(OVERFLOW), 32'd0);

    // Reset after the first word abandons the frame.
    coin_rise(t);
    push_frame(t, 16'h0000, 16'h0000, 0, 1);
    tick(2);
    SCIN_COIN = 1'b0;
    tick(WINDOW + 2);
    do_reset();
    tick(30);
    check("post_reset_busy", 32'(BUSY), 32'd0);
    check("post_reset_overflow", 32'(OVERFLOW), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
